// File: rtl/const_load_sequencer_pkg.sv
// Shared definitions for the constant-load sequencer: default widths and
// the FSM state encoding.
package const_load_sequencer_pkg;

    localparam int SIZE_DEF = 32;
    localparam int HALF_DEF = SIZE_DEF / 2;
    localparam int ADDR_W_DEF = 5;

    // Encoding is fixed so the debug state output decodes the same way
    // everywhere it is probed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LUI  = 2'd1,
        ORI  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/const_load_sequencer_if.sv
// Request and register-file write-port bundle for the constant-load sequencer.
//
// Handshakes:
//   request : a request is taken on a rising edge where req_valid && req_ready;
//             req_rd/req_imm must be stable while req_valid is high, and the
//             requester keeps req_valid high until that edge.
//   write   : a write commits on a rising edge where wr_en && wr_grant;
//             wr_en/wr_addr/wr_data hold steady until then, and wr_en never
//             depends combinationally on wr_grant.
interface const_load_sequencer_if
    import const_load_sequencer_pkg::*;
#(
    parameter int size   = SIZE_DEF,
    parameter int addr_w = ADDR_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic [addr_w-1:0] req_rd;
    logic [size-1:0]   req_imm;
    logic              wr_en;
    logic [addr_w-1:0] wr_addr;
    logic [size-1:0]   wr_data;
    logic              wr_grant;
    logic              done;
    logic              busy;
    logic [1:0]        dbg_state;

    modport slave (
        input  req_valid, req_rd, req_imm, wr_grant,
        output req_ready, wr_en, wr_addr, wr_data, done, busy, dbg_state
    );

    modport master (
        output req_valid, req_rd, req_imm, wr_grant,
        input  req_ready, wr_en, wr_addr, wr_data, done, busy, dbg_state
    );

endinterface

// File: rtl/const_load_sequencer_lui.sv
// Upper-immediate shift datapath: moves the low half of its input into the
// high half, zero-filling the low half.
module const_load_sequencer_lui
    import const_load_sequencer_pkg::*;
#(
    parameter int size = SIZE_DEF
) (
    input  logic [size-1:0] imm_in,
    output logic [size-1:0] upper
);

    localparam int half = size / 2;

    assign upper = imm_in << half;

endmodule

// File: rtl/const_load_sequencer.sv
// Constant-load sequencer: writes a full-width constant into the register
// file as an upper-half write followed by an OR-merged full write, skipping
// whichever write is redundant and never touching register 0.
module const_load_sequencer
    import const_load_sequencer_pkg::*;
#(
    parameter int size   = SIZE_DEF,
    parameter int addr_w = ADDR_W_DEF
) (
    input logic                    clk,
    input logic                    rst,
    const_load_sequencer_if.slave  bus
);

    localparam int half = size / 2;

    state_t            state;
    state_t            state_n;
    logic [addr_w-1:0] rd_q;
    logic [size-1:0]   imm_q;
    logic              accept;
    logic [size-1:0]   lui_data;
    logic [size-1:0]   ori_data;
    logic              writing;

    // rst has priority in the state register, so accept need not gate on it.
    assign accept = bus.req_valid && (state == IDLE);

    const_load_sequencer_lui #(.size(size)) u_lui (
        .imm_in ({{half{1'b0}}, imm_q[size-1:half]}),
        .upper  (lui_data)
    );

    assign ori_data = lui_data | {{half{1'b0}}, imm_q[half-1:0]};

    // Next-state: classify on accept, advance write states only on grant.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.req_rd == '0)
                        state_n = FIN;
                    else if (bus.req_imm[size-1:half] == '0)
                        state_n = ORI;
                    else
                        state_n = LUI;
                end
            end
            LUI: begin
                if (bus.wr_grant)
                    state_n = (imm_q[half-1:0] == '0) ? FIN : ORI;
            end
            ORI: begin
                if (bus.wr_grant)
                    state_n = FIN;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and captured request; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rd_q  <= '0;
            imm_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                rd_q  <= bus.req_rd;
                imm_q <= bus.req_imm;
            end
        end
    end

    // Outputs decode the registered state only; rst masks a pending write so
    // an abandoned one cannot be granted on the reset edge.
    always_comb begin
        writing       = ((state == LUI) || (state == ORI)) && !rst;
        bus.wr_en     = writing;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.req_ready = (state == IDLE) && !rst;
        bus.done      = (state == FIN) && !rst;
        bus.busy      = (state != IDLE);
        bus.dbg_state = state;
        if (writing) begin
            bus.wr_addr = rd_q;
            bus.wr_data = (state == LUI) ? lui_data : ori_data;
        end
    end

endmodule

// File: tb/tb_const_load_sequencer.sv
// Bench for the constant-load sequencer: directed scenarios plus a random
// back-to-back run, with expected register-file writes queued per request.
module tb_const_load_sequencer;

    localparam int SIZE = 32;
    localparam int AW   = 5;
    localparam int HALF = SIZE / 2;

    logic clk = 1'b0;
    logic rst;

    int errors = 0;
    int checks = 0;

    logic [AW+SIZE-1:0] exp_q[$];

    const_load_sequencer_if #(.size(SIZE), .addr_w(AW)) bus ();

    const_load_sequencer #(.size(SIZE), .addr_w(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_rd    = '0;
        bus.req_imm   = '0;
        bus.wr_grant  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
        checks++;
        if (bus.wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0h expected 0", bus.wr_addr); end
        checks++;
        if (bus.wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %0h expected 0", bus.wr_data); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b expected 0", bus.req_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", bus.req_ready); end
    endtask

    // Drive one request; s1/s2 are grant-low cycles before the first and
    // second write. Cycle 0 is the accept cycle; done is expected in cycle
    // 1 + writes + stalls.
    task automatic run_req(input string name, input logic [AW-1:0] rd,
                           input logic [SIZE-1:0] imm, input int s1, input int s2);
        int nw;
        int exp_lat;
        int lat;
        bit seen_done;
        logic [HALF-1:0] hi;
        logic [HALF-1:0] lo;
        hi = imm[SIZE-1:HALF];
        lo = imm[HALF-1:0];
        nw = 0;
        exp_q.delete();
        if (rd != '0) begin
            if (hi != '0) begin
                exp_q.push_back({rd, hi, {HALF{1'b0}}});
                nw++;
            end
            if (hi == '0 || lo != '0) begin
                exp_q.push_back({rd, imm});
                nw++;
            end
        end
        exp_lat = 1 + nw + ((nw >= 1) ? s1 : 0) + ((nw == 2) ? s2 : 0);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rd    = rd;
        bus.req_imm   = imm;
        bus.wr_grant  = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_accept: got %b expected 1", name, bus.req_ready); end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_rd    = AW'($urandom_range(0, 31));
        bus.req_imm   = $urandom;

        lat = 0;
        seen_done = 1'b0;
        for (int c = 1; c <= 40 && !seen_done; c++) begin
            if (c <= s1)                bus.wr_grant = 1'b0;
            else if (c == s1 + 1)       bus.wr_grant = 1'b1;
            else if (c <= s1 + 1 + s2)  bus.wr_grant = 1'b0;
            else                        bus.wr_grant = 1'b1;
            @(negedge clk);
            if (bus.wr_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_unexpected_write: got addr=%0d data=%h with no write pending", name, bus.wr_addr, bus.wr_data);
                end else if ({bus.wr_addr, bus.wr_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s_write: got addr=%0d data=%h expected addr=%0d data=%h (cycle %0d)", name,
                             bus.wr_addr, bus.wr_data, exp_q[0][AW+SIZE-1:SIZE], exp_q[0][SIZE-1:0], c);
                end
                if (bus.wr_grant && exp_q.size() != 0) void'(exp_q.pop_front());
            end
            checks++;
            if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_busy: got %b expected 0 (cycle %0d)", name, bus.req_ready, c); end
            if (bus.done === 1'b1) begin
                seen_done = 1'b1;
                lat = c;
            end
            @(posedge clk);
            #1;
        end
        bus.wr_grant = 1'b1;

        checks++;
        if (!seen_done) begin errors++; $display("FAIL %s_done_timeout: got no done expected done at cycle %0d", name, exp_lat); end
        else if (lat != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s_missing_writes: got %0d outstanding expected 0", name, exp_q.size()); end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b expected 0", name, bus.done); end
        checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_after: got ready=%b busy=%b expected ready=1 busy=0", name, bus.req_ready, bus.busy);
        end
    endtask

    task automatic test_full_constant();
        run_req("full", 5'd8, 32'h1234_5678, 0, 0);
    endtask

    task automatic test_low_half_zero();
        run_req("lo_zero", 5'd9, 32'hABCD_0000, 0, 0);
    endtask

    task automatic test_high_half_zero();
        run_req("hi_zero", 5'd10, 32'h0000_BEEF, 0, 0);
        run_req("imm_zero", 5'd11, 32'h0000_0000, 0, 0);
    endtask

    task automatic test_rd_zero();
        run_req("rd_zero", 5'd0, 32'hFFFF_FFFF, 0, 0);
    endtask

    task automatic test_grant_stall();
        run_req("stall", 5'd13, 32'hDEAD_1234, 3, 2);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rd    = 5'd12;
        bus.req_imm   = 32'hCAFE_F00D;
        bus.wr_grant  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd12 || bus.wr_data !== 32'hCAFE_0000) begin
            errors++;
            $display("FAIL rst_mid_lui: got en=%b addr=%0d data=%h expected en=1 addr=12 data=cafe0000",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ((bus.wr_en && bus.wr_grant) !== 1'b0) begin errors++; $display("FAIL rst_mid_commit: got write data=%h expected none", bus.wr_data); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", bus.done); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ready: got ready=%b busy=%b expected ready=1 busy=0", bus.req_ready, bus.busy);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.wr_en !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_quiet: got wr_en=%b done=%b expected 0 0 (cycle %0d)", bus.wr_en, bus.done, i);
            end
            @(negedge clk);
        end
        run_req("after_rst", 5'd12, 32'h0BAD_F00D, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0]   rd;
        logic [SIZE-1:0] imm;
        int kind;
        for (int i = 0; i < 12; i++) begin
            rd   = AW'($urandom_range(0, 31));
            imm  = $urandom;
            kind = $urandom_range(0, 2);
            if (kind == 1) imm[SIZE-1:HALF] = '0;
            if (kind == 2) imm[HALF-1:0] = '0;
            run_req("b2b", rd, imm, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_full_constant();
        test_low_half_zero();
        test_high_half_zero();
        test_rd_zero();
        test_grant_stall();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/const_load_sequencer.md
Name: const_load_sequencer

Overview:
- Multi-cycle sequencer that materialises a full-width constant into the register file as the two-step LUI/ORI pair. It uses the upper-immediate shift datapath for the high half and an OR-merge for the low half.
- Sits beside the single-cycle core. It shares the register-file write port through a grant handshake, so the core's own writeback always has priority.
- Serves assembler pseudo-ops (li/la) expanded in hardware, and the boot-time register initialisation path.

Parameters:
- size, 32, data width in bits; must be even, half = size/2.
- addr_w, 5, register address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request this cycle.
- req_rd  input  addr_w  destination register.
- req_imm  input  size  constant to load.
- wr_en  output  1  write-port request to the register file.
- wr_addr  output  addr_w  write address.
- wr_data  output  size  write data.
- wr_grant  input  1  core grants the write port this cycle; a write is committed when wr_en && wr_grant.
- done  output  1  one-cycle pulse when a request completes.
- busy  output  1  request in flight (state != IDLE).

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; wr_en=0, wr_addr=0, wr_data=0, done=0, busy=0; internal rd/imm registers cleared.
  - Reset in the middle of an operation abandons it. An uncommitted write is never issued afterwards.
- req_ready = (state==IDLE) && !rst, combinational. A request is accepted when req_valid && req_ready. req_rd and req_imm are captured at that edge.
- States: IDLE, LUI, ORI, FIN.
- IDLE, on accept, classify the request:
  - rd==0 → FIN. No writes; $zero is never written.
  - imm[size-1:half]==0 → ORI. A single write of {0, imm[half-1:0]} is enough.
  - otherwise → LUI.
- LUI:
  - wr_en=1, wr_addr=rd, wr_data={imm[size-1:half], half'b0}.
  - Hold all three outputs stable until wr_grant.
  - On grant: go to FIN if imm[half-1:0]==0, else go to ORI.
- ORI:
  - wr_en=1, wr_addr=rd, wr_data = ({imm[size-1:half], half'b0} | {half'b0, imm[half-1:0]}), which equals imm.
  - Hold until wr_grant, then go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE. A new request is accepted the cycle after FIN, never in FIN itself.
- Latency from accept to done, with grant always high:
  - 3 cycles for a two-write request.
  - 2 cycles for a single-write request.
  - 1 cycle for rd==0.
- Each cycle without wr_grant adds 1 cycle.
- wr_en is registered and never depends combinationally on wr_grant.
- A grant while wr_en=0 is ignored.
- req_valid while busy is not accepted; the requester holds it.
- The register-file value of rd between the LUI and ORI commits is transient (upper half only). Consumers must wait for done.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding localparams (IDLE=2'd0, LUI=2'd1, ORI=2'd2, FIN=2'd3);
  - the half-width constant.
- Sub-module: the existing upper-immediate shift block, instantiated for the LUI data (input {half'b0, imm_hi}). The OR-merge stays inline.

Test Plan:
- Full constant: req rd=8, imm=0x12345678, grant=1 →
  - write 0x12340000 to r8, then 0x12345678 next cycle;
  - done 3 cycles after accept; req_ready low throughout.
- Low-half zero: rd=9, imm=0xABCD0000 → a single write of 0xABCD0000; done after 2 cycles.
- High-half zero: rd=10, imm=0x0000BEEF → a single write of 0x0000BEEF. imm=0 gives a single write of 0x00000000.
- rd=0, imm=0xFFFFFFFF → no wr_en ever; done 1 cycle after accept.
- Grant stall: imm=0xDEAD1234 with grant low for 3 cycles in LUI and 2 in ORI →
  - wr_en, wr_addr and wr_data are stable while stalled;
  - exactly two commits; done at accept+8.
- Reset mid-op: assert rst one cycle after the LUI commit of 0xCAFEF00D →
  - no ORI write; done stays 0; req_ready=1 the cycle after rst deasserts;
  - the next request completes normally.
